lbp_hist: RTL
=============

LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 SHALL have parameter IMG_W, default 128, image width/height in pixels.
REQ-002 SHALL have parameter CNT_W, default 15, bin counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port lbp_valid  input  1  LBP write strobe, one pixel per cycle.
REQ-006 SHALL have port lbp_addr  input  14  pixel address, row*IMG_W+col.
REQ-007 SHALL have port lbp_data  input  8  LBP code, used as bin index.
REQ-008 SHALL have port finish  input  1  upstream LBP done; sampled as a level.
REQ-009 SHALL have port hist_ready  input  1  downstream accepts the current bin.
REQ-010 SHALL have port hist_valid  output  1  hist_bin/hist_count valid.
REQ-011 SHALL have port hist_bin  output  8  bin index being dumped.
REQ-012 SHALL have port hist_count  output  CNT_W  count for hist_bin.
REQ-013 SHALL have port hist_done  output  1  all 256 bins transferred; held high.

Function
REQ-014 SHALL implement FSM ACCUM -> DRAIN -> DUMP -> DONE; reset enters ACCUM.
REQ-015 ACCUM: each cycle with lbp_valid=1 SHALL increment bin[lbp_data] by exactly 1.
REQ-016 Increment SHALL be a 2-stage pipeline (capture, read+1+write); final count visible 2 cycles after strobe.
REQ-017 Back-to-back strobes to the same bin SHALL forward the in-flight value; N consecutive hits yield +N.
REQ-018 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-019 finish=1 in ACCUM SHALL move to DRAIN; lbp_valid coincident with that cycle SHALL still be counted.
REQ-020 DRAIN SHALL last until the pipeline is empty (2 cycles), then enter DUMP with bin pointer 0.
REQ-021 lbp_valid in DRAIN, DUMP or DONE SHALL be ignored.
REQ-022 DUMP: hist_valid=1, hist_bin=pointer, hist_count=bin[pointer]; outputs SHALL hold stable while hist_ready=0.
REQ-023 Transfer occurs on a cycle with hist_valid & hist_ready; pointer then increments.
REQ-024 Transfer of bin 255 SHALL enter DONE next cycle: hist_valid=0, hist_done=1 until reset.
REQ-025 hist_ready asserted while hist_valid=0 SHALL have no effect.

Reset
REQ-026 reset SHALL clear all 256 bins, pipeline, and pointer in one cycle; hist_valid=0, hist_bin=0, hist_count=0, hist_done=0.
REQ-027 reset mid-ACCUM or mid-DUMP SHALL abort; strobes in the reset cycle SHALL not be counted.

Configuration
REQ-028 Macro LBP_HIST_BORDER_FILTER_EN defined: strobes whose address is in row 0, row IMG_W-1, col 0 or col IMG_W-1 SHALL be discarded.
REQ-029 Macro undefined: every lbp_valid strobe SHALL be counted regardless of address.

Structure
REQ-030 Package lbp_pkg SHALL hold IMG_W default, ADDR_W=14, NUM_BINS=256, CNT_W default, and the FSM state enum.
REQ-031 Sub-module lbp_hist_ram SHALL hold the 256xCNT_W array: one sync write port, one async read port, sync clear.
REQ-032 FSM, forwarding, saturation and border filter SHALL live in lbp_hist.

Verification
REQ-033 5 strobes of code 0x3C on consecutive cycles, then finish, hist_ready=1 -> bin 0x3C=5, all other bins 0, hist_done after 256 transfers.
REQ-034 Full 128x128 frame, one strobe per address, data=addr[7:0] -> filter off: every bin=64; filter on: bins total 15876 (126*126).
REQ-035 hist_ready toggled 1-0-0-1 during DUMP -> hist_bin/hist_count frozen on low cycles; bins delivered 0..255 in order, none duplicated or skipped.
REQ-036 CNT_W=4, 20 strobes to bin 7 -> bin 7 reads 15.
REQ-037 reset asserted mid-DUMP at bin 100 -> next cycle hist_valid=0; a new frame of 3 strobes of 0x01 then dumps bin 1=3, others 0.
REQ-038 lbp_valid with data 0xFF in same cycle as finish, plus strobe during DRAIN -> bin 0xFF=1 (DRAIN strobe dropped).

Source files
------------

// File: rtl/lbp_pkg.sv
// lbp_pkg: shared constants and FSM state type for the LBP histogram block.
package lbp_pkg;
    localparam int IMG_W_DEF = 128;
    localparam int ADDR_W    = 14;
    localparam int NUM_BINS  = 256;
    localparam int BIN_W     = 8;
    localparam int CNT_W_DEF = 15;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_DUMP,
        ST_DONE
    } state_e;
endpackage

// File: rtl/lbp_hist_ram.sv
// lbp_hist_ram: NUM_BINS x CNT_W bin storage with sync write, async read and sync clear.
module lbp_hist_ram
    import lbp_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [BIN_W-1:0] wr_addr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [BIN_W-1:0] rd_addr,
    output logic [CNT_W-1:0] rd_data
);
    logic [CNT_W-1:0] mem_q [NUM_BINS];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_BINS; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: accumulates LBP codes into 256 saturating bins, then dumps them with valid/ready.
// Define LBP_HIST_BORDER_FILTER_EN to discard strobes on the outer image border.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [BIN_W-1:0]  lbp_data,
    input  logic              finish,
    input  logic              hist_ready,
    output logic              hist_valid,
    output logic [BIN_W-1:0]  hist_bin,
    output logic [CNT_W-1:0]  hist_count,
    output logic              hist_done
);
    state_e             state_q, state_d;
    logic               s1_vld_q, s1_vld_d;
    logic [BIN_W-1:0]   s1_bin_q, s1_bin_d;
    logic               wb_vld_q, wb_vld_d;
    logic [BIN_W-1:0]   wb_bin_q, wb_bin_d;
    logic [CNT_W-1:0]   wb_cnt_q, wb_cnt_d;
    logic               drain_q, drain_d;
    logic [BIN_W-1:0]   ptr_q, ptr_d;
    logic               keep;
    logic [BIN_W-1:0]   rd_addr;
    logic [CNT_W-1:0]   rd_data;
    logic [CNT_W-1:0]   cur;
    logic [CNT_W-1:0]   inc;

`ifdef LBP_HIST_BORDER_FILTER_EN
    logic [ADDR_W-1:0] row, col;
    always_comb begin
        row  = lbp_addr / ADDR_W'(IMG_W);
        col  = lbp_addr % ADDR_W'(IMG_W);
        keep = !(row == '0 || row == ADDR_W'(IMG_W - 1) || col == '0 || col == ADDR_W'(IMG_W - 1));
    end
`else
    logic unused_addr;
    assign unused_addr = ^lbp_addr;
    assign keep = 1'b1;
`endif

    // Last write is forwarded so a repeat hit never sees a stale bin value.
    always_comb begin
        rd_addr = (state_q == ST_DUMP) ? ptr_q : s1_bin_q;
        cur     = (wb_vld_q && wb_bin_q == s1_bin_q) ? wb_cnt_q : rd_data;
        inc     = (&cur) ? cur : cur + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        s1_vld_d = (state_q == ST_ACCUM) && lbp_valid && keep;
        s1_bin_d = lbp_data;
        wb_vld_d = s1_vld_q;
        wb_bin_d = s1_bin_q;
        wb_cnt_d = inc;
        drain_d  = drain_q;
        ptr_d    = ptr_q;
        case (state_q)
            ST_ACCUM: begin
                drain_d = 1'b0;
                if (finish) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = ST_DUMP;
                    ptr_d   = '0;
                end
            end
            ST_DUMP: begin
                if (hist_ready) begin
                    ptr_d = ptr_q + 1'b1;
                    if (&ptr_q) state_d = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_ACCUM;
            s1_vld_q <= 1'b0;
            s1_bin_q <= '0;
            wb_vld_q <= 1'b0;
            wb_bin_q <= '0;
            wb_cnt_q <= '0;
            drain_q  <= 1'b0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= s1_vld_d;
            s1_bin_q <= s1_bin_d;
            wb_vld_q <= wb_vld_d;
            wb_bin_q <= wb_bin_d;
            wb_cnt_q <= wb_cnt_d;
            drain_q  <= drain_d;
            ptr_q    <= ptr_d;
        end
    end

    lbp_hist_ram #(.CNT_W(CNT_W)) u_ram (
        .clk     (clk),
        .clr     (reset),
        .we      (s1_vld_q),
        .wr_addr (s1_bin_q),
        .wr_data (inc),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign hist_valid = (state_q == ST_DUMP);
    assign hist_bin   = ptr_q;
    assign hist_count = hist_valid ? rd_data : '0;
    assign hist_done  = (state_q == ST_DONE);
endmodule
